sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO for data buffering between producer and consumer logic in the same clock domain.
- Adds over the basic FIFO: occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, read-valid strobe, and non-power-of-two depth.
- Optional first-word-fall-through (FWFT) read mode, selected by macro.

Parameters:
DATA_WIDTH, 8, width of each data word in bits
DEPTH, 16, number of storage entries; any value >= 2, not restricted to powers of two
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH
AEMPTY_THRESH, 2, almost_empty asserts when count <= this value; legal range 0..DEPTH-1
Derived localparams: ADDR_W = clog2(DEPTH) (minimum 1); CNT_W = clog2(DEPTH+1)

Ports:
clk  in  1  clock; all logic on rising edge
rstn  in  1  synchronous reset, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_THRESH
rd_en  in  1  read request (pop/acknowledge in FWFT mode)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data holds a valid popped word
empty  out  1  count == 0
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write requested while full
underflow  out  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (rstn=0 at a clock edge):
  - wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow and underflow all go to 0.
  - Memory array is not reset. Reset mid-operation discards all contents; empty=1 and count=0 from the next cycle.
- Write acceptance: wr_en && !full, where full is the registered state at that edge. On accept, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Read acceptance: rd_en && !empty, using the registered state. On accept, rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. No power-of-two assumption; pointers never take values >= DEPTH.
- Count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on simultaneous accepted read and write, or on neither.
- Status flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count only (no input-to-output paths).
- Simultaneous wr_en and rd_en:
  - When full: read accepted, write rejected, overflow=1, count goes to DEPTH-1.
  - When empty: write accepted, read rejected, underflow=1, count goes to 1.
  - Otherwise both are accepted.
- Rejected write: memory and pointers unchanged, overflow=1 next cycle.
- Rejected read: rd_data holds its previous value, rd_valid=0, underflow=1 next cycle.
- Standard read mode (macro undefined):
  - rd_data <= mem[rd_ptr] on an accepted read, giving 1-cycle latency.
  - rd_valid=1 in the cycle after an accepted read, otherwise 0.
  - rd_data holds its value between reads.
- Read-during-write to the same entry cannot occur: a full FIFO rejects the write and an empty FIFO rejects the read.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN
- Defined (FWFT mode):
  - rd_data = mem[rd_ptr] combinationally and rd_valid = !empty; the head word is visible with no request.
  - rd_en acknowledges and pops the head, and the next word appears in the following cycle.
  - A word written into an empty FIFO is visible on rd_data in the cycle after the write edge.
  - rd_data is don't-care while rd_valid=0.
  - underflow rule unchanged.
- Undefined: standard registered read as described in Behaviour.

Decomposition:
- Package fifo_pkg:
  - clog2 constant function.
  - Error-pulse encoding constants shared with the async FIFO family.
  - Default width/depth constants.
- Sub-module fifo_wrap_ptr: ADDR_W-bit pointer with inc and rstn, wrapping at DEPTH-1; instantiated twice, for write and read.
- Flag decode, count and memory stay in the top module.

Test Plan:
- Fill/drain, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1: write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at 4. Read x4 -> rd_data 0x11..0x44 each one cycle after rd_en, rd_valid pulses; almost_empty at count<=1; empty at the end.
- Overflow when full: wr_en with 0x55 -> overflow pulses one cycle; count stays 4; subsequent reads return 0x11..0x44 and never 0x55.
- Underflow when empty: rd_en -> underflow=1, rd_valid=0, rd_data unchanged. Simultaneous wr_en(0xA5)+rd_en when empty -> count=1, underflow=1.
- Simultaneous read/write at count=2 -> count stays 2, FIFO order preserved. At full, both asserted -> count 3, overflow=1, written data dropped.
- Wrap, DEPTH=5: 12 interleaved writes/reads of 0x00..0x0B -> pointers wrap at 4 to 0, data order exact, count never exceeds 5.
- Reset mid-operation at count=3: rstn=0 for one edge -> count=0, empty=1, rd_valid=0. Next write 0x77 then read returns 0x77. With SYNC_FIFO_FWFT_EN, 0x77 appears on rd_data with rd_valid=1 one cycle after the write and no rd_en needed.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the synchronous FIFO family:
//               clog2 constant function, error-pulse encoding, default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Default geometry used when a FIFO is instantiated without overrides
    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 16;

    // Error-pulse encoding shared with the async FIFO family
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

    // Ceiling log2 for sizing pointers and counters; clog2(1) = 0
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
// ============================================================================
// Module      : fifo_wrap_ptr
// Description : ADDR_W-bit FIFO pointer that advances on inc_i and wraps from
//               DEPTH-1 back to 0, so any depth (not only powers of two) works.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wrap_ptr #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Next pointer: hold, increment, or wrap at the last entry
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty flags, overflow and
//               underflow pulses, read-valid strobe and arbitrary depth.
//               Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
//               otherwise reads are registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH         = FIFO_DEFAULT_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int ADDR_W       = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CNT_W        = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [1:0]            err_q;
    logic [1:0]            err_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode only the registered count, so no input reaches an output
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
    assign count        = count_q;

    // A full FIFO rejects writes and an empty one rejects reads, which also
    // rules out read-during-write on the same entry
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rstn  (rstn),
        .inc_i (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rstn  (rstn),
        .inc_i (rd_acc),
        .ptr_o (rd_ptr)
    );

    // Next occupancy and error pulses from the accepted/rejected requests
    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = ERR_NONE;
        if (wr_en && full) begin
            err_d = err_d | ERR_OVERFLOW;
        end
        if (rd_en && empty) begin
            err_d = err_d | ERR_UNDERFLOW;
        end
    end

    // Occupancy and error-pulse registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign overflow  = |(err_q & ERR_OVERFLOW);
    assign underflow = |(err_q & ERR_UNDERFLOW);

    // Storage array; intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always presented; rd_en only pops it
    assign rd_data  = mem_q[rd_ptr];
    assign rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: data appears the cycle after an accepted read and holds
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_q[rd_ptr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

`default_nettype wire
